// File: rtl/router_pkg.sv
// Shared definitions for the router packet transmitter: FSM state encoding,
// field widths, the illegal destination code and header pack/unpack helpers.
package router_pkg;

  localparam int unsigned ADDR_W      = 2;
  localparam int unsigned LEN_W       = 6;
  localparam int unsigned PTR_W       = 6;
  localparam int unsigned MAX_LEN_DEF = 63;

  // Destination 3 does not exist on the 3x1 router.
  localparam logic [ADDR_W-1:0] ADDR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StHeader  = 3'd2,
    StPayload = 3'd3,
    StParity  = 3'd4,
    StGap     = 3'd5
  } tx_state_e;

  // Header byte layout is {len, addr} with addr in the two LSBs.
  function automatic logic [LEN_W+ADDR_W-1:0] pack_header(input logic [LEN_W-1:0]  len,
                                                          input logic [ADDR_W-1:0] addr);
    return {len, addr};
  endfunction

  function automatic logic [ADDR_W-1:0] header_addr(input logic [LEN_W+ADDR_W-1:0] hdr);
    return hdr[ADDR_W-1:0];
  endfunction

  function automatic logic [LEN_W-1:0] header_len(input logic [LEN_W+ADDR_W-1:0] hdr);
    return hdr[LEN_W+ADDR_W-1:ADDR_W];
  endfunction

endpackage

// File: rtl/router_tx_buf.sv
// Payload store for one packet: synchronous write, asynchronous read.
// Contents are not reset; only locations written by the current packet are read.
module router_tx_buf #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 63,
  parameter int unsigned PTR_W = 6
) (
  input  logic             clock,
  input  logic             wr_en,
  input  logic [PTR_W-1:0] wr_ptr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [PTR_W-1:0] rd_ptr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; out-of-range pointers are dropped rather than aliased.
  always_ff @(posedge clock) begin
    if (wr_en && (32'(wr_ptr) < DEPTH)) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Read port; the pointer may sit one past the last byte after the final transfer.
  always_comb begin
    rd_data = '0;
    if (32'(rd_ptr) < DEPTH) begin
      rd_data = mem[rd_ptr];
    end
  end

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter for the 3x1 router input port. Takes a command (addr, len),
// buffers the payload, then sends header, payload and an XOR parity byte, and
// finally samples the router err flag into rx_err.
// Optional feature: define PKT_TX_PAR_INJ_EN to add the par_inj input, which
// inverts the transmitted parity byte of the commanded packet.
module router_pkt_tx
  import router_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned GAP_CYC = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
`ifdef PKT_TX_PAR_INJ_EN
  input  logic              par_inj,
`endif
  input  logic              pl_valid,
  output logic              pl_ready,
  input  logic [WIDTH-1:0]  pl_data,
  input  logic              busy,
  output logic              pkt_valid,
  output logic [WIDTH-1:0]  data_out,
  output logic              tx_done,
  output logic              cmd_err,
  output logic              rx_err,
  input  logic              err
);

  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  tx_state_e         state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [PTR_W-1:0]  wr_ptr_q;
  logic [PTR_W-1:0]  rd_ptr_q;
  logic [WIDTH-1:0]  parity_q;
  logic [GapW-1:0]   gap_cnt_q;

  logic [LEN_W-1:0]  cmd_len_clamped;
  logic [WIDTH-1:0]  hdr_cmd;
  logic [WIDTH-1:0]  hdr_q;
  logic [WIDTH-1:0]  rd_data;
  logic [WIDTH-1:0]  par_next;
  logic [WIDTH-1:0]  par_byte;
  logic              par_flip;
  logic              buf_wr_en;
  logic              cmd_acc;

`ifdef PKT_TX_PAR_INJ_EN
  logic inj_q;

  // Capture the inject request with the command it belongs to.
  always_ff @(posedge clock) begin
    if (reset) begin
      inj_q <= 1'b0;
    end else if (cmd_acc) begin
      inj_q <= par_inj;
    end
  end

  assign par_flip = inj_q;
`else
  assign par_flip = 1'b0;
`endif

  // Handshake decodes, length clamp and header/parity byte formation.
  always_comb begin
    cmd_ready       = (state_q == StIdle);
    pl_ready        = (state_q == StLoad) && (wr_ptr_q < len_q);
    cmd_acc         = cmd_valid && cmd_ready;
    buf_wr_en       = pl_valid && pl_ready;
    cmd_len_clamped = (32'(cmd_len) > MAX_LEN) ? LEN_W'(MAX_LEN) : cmd_len;
    hdr_cmd         = WIDTH'(pack_header(cmd_len_clamped, cmd_addr));
    hdr_q           = WIDTH'(pack_header(len_q, addr_q));
    // data_out always holds the byte being transferred in HEADER/PAYLOAD.
    par_next        = parity_q ^ data_out;
    par_byte        = par_next ^ {WIDTH{par_flip}};
  end

  router_tx_buf #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_LEN),
    .PTR_W (PTR_W)
  ) u_buf (
    .clock   (clock),
    .wr_en   (buf_wr_en),
    .wr_ptr  (wr_ptr_q),
    .wr_data (pl_data),
    .rd_ptr  (rd_ptr_q),
    .rd_data (rd_data)
  );

  // Transmit FSM with registered router-side outputs; busy freezes all send states.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      len_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      parity_q  <= '0;
      gap_cnt_q <= '0;
      pkt_valid <= 1'b0;
      data_out  <= '0;
      tx_done   <= 1'b0;
      cmd_err   <= 1'b0;
      rx_err    <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      cmd_err <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cmd_acc) begin
            if (cmd_addr == ADDR_ILLEGAL) begin
              cmd_err <= 1'b1;
            end else begin
              addr_q   <= cmd_addr;
              len_q    <= cmd_len_clamped;
              wr_ptr_q <= '0;
              rd_ptr_q <= '0;
              parity_q <= '0;
              rx_err   <= 1'b0;
              if (cmd_len_clamped == '0) begin
                state_q   <= StHeader;
                pkt_valid <= 1'b1;
                data_out  <= hdr_cmd;
              end else begin
                state_q <= StLoad;
              end
            end
          end
        end
        StLoad: begin
          if (buf_wr_en) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if ((wr_ptr_q + PTR_W'(1)) == len_q) begin
              state_q   <= StHeader;
              pkt_valid <= 1'b1;
              data_out  <= hdr_q;
            end
          end
        end
        StHeader: begin
          if (!busy) begin
            parity_q <= par_next;
            if (len_q == '0) begin
              state_q   <= StParity;
              pkt_valid <= 1'b0;
              data_out  <= par_byte;
            end else begin
              state_q  <= StPayload;
              data_out <= rd_data;
              rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
          end
        end
        StPayload: begin
          if (!busy) begin
            parity_q <= par_next;
            // rd_ptr_q already points past the byte on data_out.
            if (rd_ptr_q == len_q) begin
              state_q   <= StParity;
              pkt_valid <= 1'b0;
              data_out  <= par_byte;
            end else begin
              data_out <= rd_data;
              rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
          end
        end
        StParity: begin
          if (!busy) begin
            tx_done   <= 1'b1;
            gap_cnt_q <= '0;
            state_q   <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt_q == GapW'(GAP_CYC - 1)) begin
            rx_err  <= err;
            state_q <= StIdle;
          end else begin
            gap_cnt_q <= gap_cnt_q + GapW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed + randomized bench for router_pkt_tx. Expected packets are built from
// the wire format: header {len,addr}, payload bytes, XOR of all of them.
module tb_router_pkt_tx;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
`ifdef PKT_TX_PAR_INJ_EN
  logic       par_inj;
`endif
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_done;
  logic       cmd_err;
  logic       rx_err;
  logic       err;

  int checks;
  int errors;
  logic [7:0] stim_q[$];

  router_pkt_tx dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
`ifdef PKT_TX_PAR_INJ_EN
    .par_inj   (par_inj),
`endif
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .pkt_valid (pkt_valid),
    .data_out  (data_out),
    .tx_done   (tx_done),
    .cmd_err   (cmd_err),
    .rx_err    (rx_err),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends the packet held in stim_q and checks it end to end.
  // busy_mode: 0 none, 1 random stalls, 2 hold three cycles while hold_byte is presented.
  task automatic run_packet(input logic [1:0] addr, input int busy_mode,
                            input logic [7:0] hold_byte, input bit err_val, input bit inj);
    int         len, idx, cyc, last_load, hdr_cyc, hold_cnt, seen_hold;
    bit         done, started, dropped, bubble, par_v, b, eff_inj;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] hdr, par_exp, par_got;
    logic [5:0] len6;

    len  = stim_q.size();
    len6 = 6'(len);
    hdr  = {len6, addr};
    exp_q.push_back(hdr);
    par_exp = hdr;
    foreach (stim_q[i]) begin
      exp_q.push_back(stim_q[i]);
      par_exp ^= stim_q[i];
    end
`ifdef PKT_TX_PAR_INJ_EN
    eff_inj = inj;
`else
    eff_inj = 1'b0;
`endif
    if (eff_inj) par_exp = ~par_exp;

    cyc = 0;
    @(negedge clock);
    while (!cmd_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len6;
`ifdef PKT_TX_PAR_INJ_EN
    par_inj   = inj;
`endif
    err       = err_val;

    last_load = (len == 0) ? 0 : -100;
    hdr_cyc = -1; idx = 0; cyc = 0; hold_cnt = 0; seen_hold = 0;
    done = 0; started = 0; dropped = 0; bubble = 0; par_v = 1'b1; par_got = '0;
    while (!done && cyc < 3000) begin
      @(negedge clock);
      cyc++;
      cmd_valid = 1'b0;
      if (cyc == 1) check("cmd_ready_drop", cmd_ready, 0);
      if (tx_done) begin
        done     = 1;
        par_got  = data_out;
        par_v    = pkt_valid;
        busy     = 1'b0;
        pl_valid = 1'b0;
      end else begin
        case (busy_mode)
          1:       b = ($urandom_range(0, 3) == 0);
          2:       b = pkt_valid && (data_out == hold_byte) && (hold_cnt < 3);
          default: b = 1'b0;
        endcase
        if (busy_mode == 2 && b) hold_cnt++;
        busy = b;
        if (pkt_valid) begin
          if (!started) hdr_cyc = cyc;
          started = 1;
          if (dropped) bubble = 1;
          if (!b) got_q.push_back(data_out);
          if (data_out == hold_byte) seen_hold++;
        end else if (started) begin
          dropped = 1;
        end
        if (pl_ready && idx < len && $urandom_range(0, 3) != 0) begin
          pl_valid = 1'b1;
          pl_data  = stim_q[idx];
          idx++;
          if (idx == len) last_load = cyc;
        end else begin
          pl_valid = 1'b0;
          pl_data  = 8'($urandom);
        end
      end
    end
    check("tx_done_timeout", 32'(done), 1);
    check("byte_count", got_q.size(), exp_q.size());
    if (got_q.size() == exp_q.size()) begin
      foreach (got_q[i]) check("pkt_byte", got_q[i], exp_q[i]);
    end
    check("parity_byte", par_got, par_exp);
    check("parity_pkt_valid", par_v, 0);
    check("no_bubble", bubble, 0);
    check("header_latency", hdr_cyc, last_load + 1);
    if (busy_mode == 2) check("busy_hold_cycles", seen_hold, 4);
    check("gap_ready0", cmd_ready, 0);
    @(negedge clock);
    check("tx_done_pulse", tx_done, 0);
    check("gap_ready1", cmd_ready, 0);
    @(negedge clock);
    check("gap_end_ready", cmd_ready, 1);
    check("rx_err_sample", rx_err, err_val);
  endtask

  initial begin
    int nv, cyc;
    checks = 0; errors = 0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0;
`ifdef PKT_TX_PAR_INJ_EN
    par_inj = 1'b0;
`endif
    pl_valid = 1'b0; pl_data = '0; busy = 1'b0; err = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_data_out", data_out, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_pl_ready", pl_ready, 0);
    check("rst_tx_done", tx_done, 0);
    check("rst_cmd_err", cmd_err, 0);
    check("rst_rx_err", rx_err, 0);

    // Basic packet: 0D 11 22 33, parity 0D.
    stim_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 0, 8'h00, 1'b0, 1'b0);

    // Same packet, stalled three cycles on byte 22.
    stim_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 2, 8'h22, 1'b0, 1'b0);

    // Illegal destination is rejected without touching the payload port.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd5; pl_valid = 1'b1;
    @(negedge clock);
    check("illegal_cmd_err", cmd_err, 1);
    check("illegal_cmd_ready", cmd_ready, 1);
    check("illegal_pkt_valid", pkt_valid, 0);
    check("illegal_pl_ready", pl_ready, 0);
    cmd_valid = 1'b0; pl_valid = 1'b0;
    @(negedge clock);
    check("illegal_err_pulse", cmd_err, 0);
    check("illegal_pl_ready2", pl_ready, 0);

    // Zero-length packet: header 02, parity 02.
    stim_q = {};
    run_packet(2'd2, 0, 8'h00, 1'b0, 1'b0);

    // Router error is captured and held through idle and a rejected command.
    stim_q = '{8'h5A, 8'hC3};
    run_packet(2'd0, 1, 8'h00, 1'b1, 1'b0);
    repeat (3) @(negedge clock);
    check("rx_err_hold_idle", rx_err, 1);
    cmd_valid = 1'b1; cmd_addr = 2'd3; cmd_len = 6'd1;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rx_err_hold_illegal", rx_err, 1);
    cmd_valid = 1'b1; cmd_addr = 2'd1; cmd_len = 6'd0; err = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    check("rx_err_clear_on_cmd", rx_err, 0);
    cyc = 0;
    while (!cmd_ready && cyc < 50) begin
      @(negedge clock);
      cyc++;
    end
    check("drain_ready", cmd_ready, 1);

`ifdef PKT_TX_PAR_INJ_EN
    // Injected parity error: F2 instead of 0D, router flags it.
    stim_q = '{8'h11, 8'h22, 8'h33};
    run_packet(2'd1, 0, 8'h00, 1'b1, 1'b1);
`endif

    // Reset in the middle of the payload aborts the packet.
    @(negedge clock);
    cmd_valid = 1'b1; cmd_addr = 2'd0; cmd_len = 6'd5;
    nv = 0; cyc = 0;
    while (nv < 3 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      cmd_valid = 1'b0;
      if (pkt_valid) nv++;
      if (pl_ready) begin
        pl_valid = 1'b1;
        pl_data  = 8'($urandom);
      end else begin
        pl_valid = 1'b0;
      end
    end
    check("abort_reach_payload", nv, 3);
    reset = 1'b1; pl_valid = 1'b0;
    @(negedge clock);
    check("abort_pkt_valid", pkt_valid, 0);
    check("abort_data_out", data_out, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_tx_done", tx_done, 0);
    reset = 1'b0;
    stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    run_packet(2'd2, 0, 8'h00, 1'b0, 1'b0);

    // Random packets with random stalls, including the maximum length.
    for (int n = 0; n < 6; n++) begin
      int l;
      l = (n == 5) ? 63 : int'($urandom_range(0, 20));
      stim_q = {};
      for (int k = 0; k < l; k++) stim_q.push_back(8'($urandom));
      run_packet(2'($urandom_range(0, 2)), 1, 8'h00, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
